alu_arbiter: RTL and testbench

Shares the single combinational ALU (`alunit`) between two requesters, for example the core issue stage and a debug/co-processor port. It uses a valid/ready handshake, two-way round-robin arbitration and a registered response. The block sits between the requesters and the ALU: it drives the ALU operand and control inputs, then captures result and flags into a response register.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_arbiter_rr_pick2.sv | 24 ++
 rtl/alu_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter and anything that talks to the ALU:
//   - default datapath widths (ALU_DATA_W, ALU_OP_W)
//   - ALU op-code encodings (ADD = 0000 ... BLT = 1010; 1011-1111 undefined)
//   - arbiter FSM state enum
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_DATA_W = 32;
   localparam int ALU_OP_W   = 4;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_DIV = 4'b0100;
   localparam logic [3:0] OP_REM = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_SLL = 4'b0111;
   localparam logic [3:0] OP_SRL = 4'b1000;
   localparam logic [3:0] OP_BEQ = 4'b1001;
   localparam logic [3:0] OP_BLT = 4'b1010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arbState_t;

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
// Ports:
//   i_valid0, i_valid1 : request valids
//   i_lastGrant        : index of the requester granted most recently
//   o_grant[1:0]       : one-hot grant (all zero when nothing is valid)
// ---------------------------------------------------------------------------
module rr_pick2 (
   input  logic       i_valid0,
   input  logic       i_valid1,
   input  logic       i_lastGrant,
   output logic [1:0] o_grant
);

   // A sole requester always wins; on a tie the requester that was not
   // served last time gets the grant.
   always_comb begin
      o_grant    = 2'b00;
      o_grant[0] = i_valid0 && (!i_valid1 || i_lastGrant);
      o_grant[1] = i_valid1 && (!i_valid0 || !i_lastGrant);
   end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between two requesters using a
// valid/ready handshake, two-way round-robin arbitration and a registered
// response. Every operation takes IDLE -> EXEC -> RESP (3 cycles minimum).
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   rX_valid/rX_ready               : request handshake, X = 0/1
//   rX_srcA/rX_srcB/rX_op           : request operands and op code
//   rsp_valid/rsp_ready             : response handshake
//   rsp_id/rsp_result               : owning requester and captured result
//   rsp_zero/rsp_hero/rsp_err       : beq / blt outcome, divide-by-zero flag
//   alu_srcA/alu_srcB/alu_ctrl      : drive the ALU
//   alu_result/alu_zero/alu_hero    : from the ALU
// Optional feature macro: ALU_ARB_DIV_GUARD_EN
//   When defined, div/rem by zero bypasses the ALU: result is -1 (div) or
//   srcA (rem), rsp_err is set and alu_ctrl is driven 0000 during EXEC.
//   When undefined, the ALU result passes through and rsp_err is tied 0.
// ---------------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int OP_W   = ALU_OP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_valid,
   input  logic              r1_valid,
   output logic              r0_ready,
   output logic              r1_ready,
   input  logic [DATA_W-1:0] r0_srcA,
   input  logic [DATA_W-1:0] r0_srcB,
   input  logic [DATA_W-1:0] r1_srcA,
   input  logic [DATA_W-1:0] r1_srcB,
   input  logic [OP_W-1:0]   r0_op,
   input  logic [OP_W-1:0]   r1_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              rsp_hero,
   output logic              rsp_err,
   output logic [DATA_W-1:0] alu_srcA,
   output logic [DATA_W-1:0] alu_srcB,
   output logic [OP_W-1:0]   alu_ctrl,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_hero
);

   arbState_t         r_state;
   logic              r_lastGrant;
   logic              r_id;
   logic [DATA_W-1:0] r_srcA;
   logic [DATA_W-1:0] r_srcB;
   logic [OP_W-1:0]   r_op;
   logic              r_rspValid;
   logic              r_rspId;
   logic [DATA_W-1:0] r_rspResult;
   logic              r_rspZero;
   logic              r_rspHero;

   logic [1:0]        w_grant;
   logic              w_idle;
   logic              w_accept;
   logic [DATA_W-1:0] w_selSrcA;
   logic [DATA_W-1:0] w_selSrcB;
   logic [OP_W-1:0]   w_selOp;
   logic              w_opIsBeq;
   logic              w_opIsBlt;
   logic              w_opNoResult;

   rr_pick2 u_pick (
      .i_valid0    (r0_valid),
      .i_valid1    (r1_valid),
      .i_lastGrant (r_lastGrant),
      .o_grant     (w_grant)
   );

   // Ready is only offered in IDLE and is forced low while reset is held,
   // so nothing can be accepted in the same cycle the block is being reset.
   assign w_idle    = rst_n && (r_state == ST_IDLE);
   assign r0_ready  = w_idle && w_grant[0];
   assign r1_ready  = w_idle && w_grant[1];
   assign w_accept  = r0_ready || r1_ready;

   assign w_selSrcA = w_grant[1] ? r1_srcA : r0_srcA;
   assign w_selSrcB = w_grant[1] ? r1_srcB : r0_srcB;
   assign w_selOp   = w_grant[1] ? r1_op   : r0_op;

   // The ALU keeps its branch flags from earlier compares, so they are only
   // trusted for the matching branch op. Branch ops and the undefined codes
   // above BLT produce no arithmetic result.
   assign w_opIsBeq    = (r_op == OP_W'(OP_BEQ));
   assign w_opIsBlt    = (r_op == OP_W'(OP_BLT));
   assign w_opNoResult = (r_op >= OP_W'(OP_BEQ));

   assign alu_srcA   = r_srcA;
   assign alu_srcB   = r_srcB;
   assign rsp_valid  = r_rspValid;
   assign rsp_id     = r_rspId;
   assign rsp_result = r_rspResult;
   assign rsp_zero   = r_rspZero;
   assign rsp_hero   = r_rspHero;

`ifdef ALU_ARB_DIV_GUARD_EN
   logic              r_ctrl;
   logic [OP_W-1:0]   r_ctrlOp;
   logic              r_guard;
   logic              r_rspErr;
   logic              w_selDivZero;

   // Division or remainder by zero is detected at accept time so the ALU
   // can be handed a harmless ADD instead of the trapping op.
   assign w_selDivZero = ((w_selOp == OP_W'(OP_DIV)) || (w_selOp == OP_W'(OP_REM)))
                         && (w_selSrcB == '0);
   assign alu_ctrl     = r_ctrlOp;
   assign rsp_err      = r_rspErr;
`else
   assign alu_ctrl     = r_op;
   assign rsp_err      = 1'b0;
`endif

   // Main FSM: IDLE latches the granted request, EXEC samples the ALU into
   // the response registers, RESP holds them until the consumer takes them.
   // Reset drops any in-flight transaction without producing a response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_lastGrant <= 1'b1;
         r_id        <= 1'b0;
         r_srcA      <= '0;
         r_srcB      <= '0;
         r_op        <= '0;
         r_rspValid  <= 1'b0;
         r_rspId     <= 1'b0;
         r_rspResult <= '0;
         r_rspZero   <= 1'b0;
         r_rspHero   <= 1'b0;
`ifdef ALU_ARB_DIV_GUARD_EN
         r_ctrlOp    <= '0;
         r_guard     <= 1'b0;
         r_rspErr    <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_srcA      <= w_selSrcA;
                  r_srcB      <= w_selSrcB;
                  r_op        <= w_selOp;
                  r_id        <= w_grant[1];
                  r_lastGrant <= w_grant[1];
`ifdef ALU_ARB_DIV_GUARD_EN
                  r_guard     <= w_selDivZero;
                  r_ctrlOp    <= w_selDivZero ? '0 : w_selOp;
`endif
                  r_state     <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_rspId     <= r_id;
               r_rspZero   <= w_opIsBeq && alu_zero;
               r_rspHero   <= w_opIsBlt && alu_hero;
               r_rspResult <= w_opNoResult ? '0 : alu_result;
`ifdef ALU_ARB_DIV_GUARD_EN
               r_rspErr    <= r_guard;
               if (r_guard) begin
                  r_rspResult <= (r_op == OP_W'(OP_DIV)) ? '1 : r_srcA;
               end
`endif
               r_rspValid  <= 1'b1;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rspValid <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. A behavioural ALU sits beside the DUT.
// A monitor on the falling edge keeps a transaction-level reference model
// (idle/busy, last grant, cycles since accept), pushes the expected response
// on every accept and pops/compares whenever the DUT presents a response.
// Optional feature macro: ALU_ARB_DIV_GUARD_EN (expectations follow it).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int DW = 32;
   localparam int OW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          r0_valid, r1_valid, r0_ready, r1_ready;
   logic [DW-1:0] r0_srcA, r0_srcB, r1_srcA, r1_srcB;
   logic [OW-1:0] r0_op, r1_op;
   logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_hero, rsp_err;
   logic [DW-1:0] rsp_result;
   logic [DW-1:0] alu_srcA, alu_srcB, alu_result;
   logic [OW-1:0] alu_ctrl;
   logic          alu_zero, alu_hero;

   typedef struct packed {
      logic          id;
      logic [DW-1:0] result;
      logic          zero;
      logic          hero;
      logic          err;
   } rsp_t;

   rsp_t expQ[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   mBusy = 1'b0;
   int   mCnt = 0;
   bit   mLast = 1'b1;

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r1_valid(r1_valid),
      .r0_ready(r0_ready), .r1_ready(r1_ready),
      .r0_srcA(r0_srcA), .r0_srcB(r0_srcB), .r1_srcA(r1_srcA), .r1_srcB(r1_srcB),
      .r0_op(r0_op), .r1_op(r1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_hero(rsp_hero),
      .rsp_err(rsp_err),
      .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_hero(alu_hero)
   );

   // Reference arithmetic for every op. Undefined and branch codes return
   // junk so that the DUT's zero-forcing is visible; divide by zero returns a
   // recognisable marker instead of X.
   function automatic logic [DW-1:0] aluRef(input logic [OW-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_DIV:  return (b == '0) ? 32'hDEAD_BEEF : DW'($signed(a) / $signed(b));
         OP_REM:  return (b == '0) ? 32'hDEAD_BEEF : DW'($signed(a) % $signed(b));
         OP_XOR:  return a ^ b;
         OP_SLL:  return a << b[4:0];
         OP_SRL:  return a >> b[4:0];
         OP_BEQ:  return a - b + 32'd1;
         OP_BLT:  return b - a + 32'd3;
         default: return a ^ b ^ 32'hA5A5_0F0F;
      endcase
   endfunction

   // Behavioural ALU: the flags are produced for every op, mimicking an ALU
   // whose branch flags are stale unless a branch op is actually running.
   always_comb begin
      alu_result = aluRef(alu_ctrl, alu_srcA, alu_srcB);
      alu_zero   = (alu_srcA == alu_srcB);
      alu_hero   = ($signed(alu_srcA) < $signed(alu_srcB));
   end

   // Expected response for one accepted request, from the op's meaning.
   function automatic rsp_t modelRsp(input logic id, input logic [OW-1:0] op,
                                     input logic [DW-1:0] a, input logic [DW-1:0] b);
      rsp_t m;
      m.id     = id;
      m.err    = 1'b0;
      m.zero   = (op == OP_BEQ) && (a == b);
      m.hero   = (op == OP_BLT) && ($signed(a) < $signed(b));
      m.result = (op >= OP_BEQ) ? '0 : aluRef(op, a, b);
`ifdef ALU_ARB_DIV_GUARD_EN
      if (((op == OP_DIV) || (op == OP_REM)) && (b == '0)) begin
         m.result = (op == OP_DIV) ? 32'hFFFF_FFFF : a;
         m.err    = 1'b1;
      end
`endif
      return m;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard: runs on the falling edge, away from DUT updates.
   always @(negedge clk) begin
      logic g0, g1;
      rsp_t act;
      if (!rst_n) begin
         checkOutput("ready_in_reset", 64'({r0_ready, r1_ready}), 64'd0);
         expQ.delete();
         mBusy = 1'b0;
         mCnt  = 0;
         mLast = 1'b1;
      end else begin
         g0 = 1'b0;
         g1 = 1'b0;
         if (mBusy) mCnt++;
         else if (r0_valid && r1_valid) begin
            g0 = mLast;
            g1 = !mLast;
         end else begin
            g0 = r0_valid;
            g1 = r1_valid;
         end
         checkOutput("ready", 64'({r0_ready, r1_ready}), 64'({g0, g1}));
         checkOutput("rsp_valid", 64'(rsp_valid), 64'(mBusy && (mCnt >= 2)));
         if (rsp_valid) begin
            act.id = rsp_id;  act.result = rsp_result;
            act.zero = rsp_zero; act.hero = rsp_hero; act.err = rsp_err;
            if (expQ.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL response_unexpected: got rsp 0x%0h, expected no pending response", act);
            end else begin
               checkOutput("response", 64'(act), 64'(expQ[0]));
            end
            if (rsp_ready) begin
               if (expQ.size() > 0) void'(expQ.pop_front());
               mBusy = 1'b0;
            end
         end else if (g0 || g1) begin
            expQ.push_back(modelRsp(g1, g1 ? r1_op : r0_op,
                                    g1 ? r1_srcA : r0_srcA, g1 ? r1_srcB : r0_srcB));
            mBusy = 1'b1;
            mCnt  = 0;
            mLast = g1;
         end
      end
   end

   // Drive one cycle of inputs, then advance to just after the next edge.
   task automatic applyStimulus(input logic v0, input logic [OW-1:0] op0,
                                input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                                input logic v1, input logic [OW-1:0] op1,
                                input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                                input logic rr);
      r0_valid = v0; r0_op = op0; r0_srcA = a0; r0_srcB = b0;
      r1_valid = v1; r1_op = op1; r1_srcA = a1; r1_srcB = b1;
      rsp_ready = rr;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, '0, 0, '0, '0, '0, 1);
   endtask

   // Hold a single request until it is accepted (bounded wait).
   task automatic sendReq(input logic id, input logic [OW-1:0] op,
                          input logic [DW-1:0] a, input logic [DW-1:0] b, input logic rr);
      bit got;
      got = 1'b0;
      r0_valid = !id; r0_op = op; r0_srcA = a; r0_srcB = b;
      r1_valid = id;  r1_op = op; r1_srcA = a; r1_srcB = b;
      rsp_ready = rr;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = id ? r1_ready : r0_ready;
         @(posedge clk);
         #1;
      end
      if (!got) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL accept_timeout: got no ready, expected ready within 40 cycles");
      end
      r0_valid = 1'b0;
      r1_valid = 1'b0;
   endtask

   task automatic doReset(input int n);
      rst_n = 1'b0;
      idleCycles(n);
      rst_n = 1'b1;
   endtask

   task automatic checkResetState();
      @(negedge clk);
      checkOutput("rst_rsp_result", 64'(rsp_result), 64'd0);
      checkOutput("rst_rsp_flags", 64'({rsp_valid, rsp_id, rsp_zero, rsp_hero, rsp_err}), 64'd0);
      checkOutput("rst_alu_operands", {alu_srcA, alu_srcB}, 64'd0);
      checkOutput("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic          v0, v1, rr;
      logic [OW-1:0] op0, op1;
      logic [DW-1:0] a0, b0, a1, b1;

      r0_valid = 0; r1_valid = 0; rsp_ready = 0;
      r0_op = '0; r1_op = '0; r0_srcA = '0; r0_srcB = '0; r1_srcA = '0; r1_srcB = '0;
      #1;
      doReset(3);
      checkResetState();

      $display("[TB] single requester ADD 5 + 7");
      sendReq(0, OP_ADD, 32'd5, 32'd7, 1);
      idleCycles(4);

      $display("[TB] both requesters valid every cycle after reset");
      doReset(2);
      for (int i = 0; i < 16; i++)
         applyStimulus(1, OP_SUB, 32'(100 + i), 32'(i), 1, OP_SUB, 32'(500 + i), 32'(3 * i), 1);
      idleCycles(4);

      $display("[TB] BEQ followed by ADD on r1");
      sendReq(1, OP_BEQ, 32'd3, 32'd3, 1);
      idleCycles(3);
      sendReq(1, OP_ADD, 32'd3, 32'd3, 1);
      idleCycles(3);
      sendReq(0, OP_BLT, 32'hFFFF_FFFE, 32'd4, 1);
      idleCycles(3);

      $display("[TB] response stall with both requesters waiting");
      sendReq(0, OP_XOR, 32'h0000_1234, 32'h0000_0F0F, 0);
      for (int i = 0; i < 7; i++)
         applyStimulus(1, OP_ADD, 32'd1, 32'd2, 1, OP_ADD, 32'd3, 32'd4, 0);
      idleCycles(4);

      $display("[TB] reset during EXEC");
      sendReq(0, OP_ADD, 32'd11, 32'd22, 1);
      doReset(2);
      checkResetState();
      applyStimulus(1, OP_OR, 32'h00F0, 32'h000F, 1, OP_AND, 32'hFF00, 32'h0FF0, 1);
      idleCycles(4);

      $display("[TB] divide and remainder corner cases");
      sendReq(0, OP_DIV, 32'hFFFF_FFF7, 32'd0, 1);
`ifdef ALU_ARB_DIV_GUARD_EN
      @(negedge clk);
      checkOutput("guard_alu_ctrl", 64'(alu_ctrl), 64'd0);
      @(posedge clk);
      #1;
`endif
      idleCycles(3);
      sendReq(1, OP_REM, 32'd10, 32'd0, 1);
      idleCycles(3);
      sendReq(0, OP_DIV, 32'hFFFF_FFF7, 32'd2, 1);
      idleCycles(3);
      sendReq(1, OP_REM, 32'hFFFF_FFF7, 32'd4, 1);
      idleCycles(3);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         v0  = ($urandom % 2) == 0;
         v1  = ($urandom % 3) != 0;
         rr  = ($urandom % 4) != 0;
         op0 = OW'($urandom % 16);
         op1 = OW'($urandom % 16);
         if (op0 == OP_DIV || op0 == OP_REM) begin
            a0 = 32'($urandom_range(2000) - 1000);
            b0 = (($urandom % 4) == 0) ? 32'd0 : 32'($urandom_range(200) - 100);
         end else begin
            a0 = $urandom;
            b0 = (($urandom % 4) == 0) ? a0 : $urandom;
         end
         if (op1 == OP_DIV || op1 == OP_REM) begin
            a1 = 32'($urandom_range(2000) - 1000);
            b1 = (($urandom % 4) == 0) ? 32'd0 : 32'($urandom_range(200) - 100);
         end else begin
            a1 = $urandom;
            b1 = (($urandom % 4) == 0) ? a1 : $urandom;
         end
         applyStimulus(v0, op0, a0, b0, v1, op1, a1, b1, rr);
      end
      idleCycles(6);
      @(negedge clk);
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
